// File: rtl/risk_def.sv
// Shared types and defaults for the pre-trade risk gate and its order FIFO.
package risk_def;

  localparam int DEF_CLIENT_W = 10;
  localparam int DEF_AMT_W    = 16;

  // Reject reason codes carried on rej_reason.
  typedef enum logic [1:0] {
    REJ_NONE   = 2'b00,
    REJ_LIMIT  = 2'b01,
    REJ_HALTED = 2'b10,
    REJ_ZERO   = 2'b11
  } rej_reason_t;

  // Gate operating mode: normal checking or kill switch engaged.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } gate_state_t;

  // One queued order as it travels to the exchange.
  typedef struct packed {
    logic [DEF_CLIENT_W-1:0] client_id;
    logic [DEF_AMT_W-1:0]    amount;
  } order_t;

endpackage

// File: rtl/risk_order_fifo.sv
// Synchronous order FIFO; HRESETn flushes the pointers and count, not the storage.
module risk_order_fifo
  import risk_def::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   HRESETn,
  input  logic   push,
  input  order_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output order_t head
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  order_t           mem [DEPTH];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; a flush only clears pointers, so stale data is never read.
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/pretrade_risk_gate.sv
// Pre-trade risk gate: checks each CPU order against live exposure, queues
// safe orders towards the exchange and rejects the rest with a reason code.
// CLIENT_W/AMT_W must match the risk_def defaults that size order_t.
module pretrade_risk_gate
  import risk_def::*;
#(
  parameter int CLIENT_W   = DEF_CLIENT_W,
  parameter int AMT_W      = DEF_AMT_W,
  parameter int DEPTH      = 4,
  parameter int HALT_AFTER = 3
) (
  input  logic                clk,
  input  logic                HRESETn,
  input  logic                ord_valid,
  output logic                ord_ready,
  input  logic [CLIENT_W-1:0] ord_client_id,
  input  logic [AMT_W-1:0]    ord_amount,
  input  logic [15:0]         accumulated_orders,
  input  logic [31:0]         cancelled_orders,
  input  logic [31:0]         max_to_trade,
  input  logic                clear_halt,
  output logic                exch_valid,
  input  logic                exch_ready,
  output logic [CLIENT_W-1:0] exch_client_id,
  output logic [AMT_W-1:0]    exch_amount,
  output logic                rej_valid,
  output logic [CLIENT_W-1:0] rej_client_id,
  output logic [1:0]          rej_reason,
  output logic                halted,
  output logic [AMT_W+1:0]    inflight_amt
);

  localparam int IW = AMT_W + 2;   // in-flight accumulator width
  localparam int EW = AMT_W + 3;   // signed exposure width
  localparam int CW = $clog2(HALT_AFTER + 1);

  gate_state_t state, state_next;
  logic [CW-1:0] rej_cnt, rej_cnt_next;

  logic        fifo_full, fifo_empty;
  logic        accept, push, pop;
  order_t      push_data, head;
  rej_reason_t reason, rej_reason_q;
  logic [EW-1:0] expo, limit;
  logic          limit_ok;

  // Upper halves of the 32-bit risk inputs carry no meaning here.
  logic unused_hi;
  assign unused_hi = ^{cancelled_orders[31:16], max_to_trade[31:16]};

  assign ord_ready  = !fifo_full;
  assign accept     = ord_valid && ord_ready;
  assign exch_valid = !fifo_empty;
  assign pop        = exch_valid && exch_ready;
  assign push       = accept && (reason == REJ_NONE);
  assign halted     = (state == ST_HALT);

  assign push_data.client_id = ord_client_id;
  assign push_data.amount    = ord_amount;

  // Exposure if this order were added: filled minus cancelled plus queued plus new.
  assign expo = EW'(accumulated_orders) - EW'(cancelled_orders[15:0])
              + EW'(inflight_amt) + EW'(ord_amount);
  assign limit    = EW'(max_to_trade[15:0]);
  assign limit_ok = $signed(limit) > $signed(expo);

  // Decision for the offered order; halt outranks zero amount, which outranks the limit.
  always_comb begin
    // NOTE: a default is assigned before any branch so no path leaves reason unassigned (no latch).
    reason = REJ_NONE;
    if (state == ST_HALT)        reason = REJ_HALTED;
    else if (ord_amount == '0)   reason = REJ_ZERO;
    else if (!limit_ok)          reason = REJ_LIMIT;
  end

  // Kill-switch next state: consecutive limit rejects trip it, clear_halt releases it.
  always_comb begin
    state_next   = state;
    rej_cnt_next = rej_cnt;
    case (state)
      ST_RUN: begin
        if (accept && reason == REJ_LIMIT) begin
          rej_cnt_next = rej_cnt + 1'b1;
          if (rej_cnt == CW'(HALT_AFTER - 1)) state_next = ST_HALT;
        end else if (push) begin
          rej_cnt_next = '0;
        end
      end
      ST_HALT: begin
        if (clear_halt) begin
          state_next   = ST_RUN;
          rej_cnt_next = '0;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Kill-switch state register.
  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      state   <= ST_RUN;
      rej_cnt <= '0;
    end else begin
      state   <= state_next;
      rej_cnt <= rej_cnt_next;
    end
  end

  // One-cycle reject pulse carrying the client id and reason of the refused order.
  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      rej_valid     <= 1'b0;
      rej_client_id <= '0;
      rej_reason_q  <= REJ_NONE;
    end else if (accept && reason != REJ_NONE) begin
      rej_valid     <= 1'b1;
      rej_client_id <= ord_client_id;
      rej_reason_q  <= reason;
    end else begin
      rej_valid     <= 1'b0;
      rej_client_id <= '0;
      rej_reason_q  <= REJ_NONE;
    end
  end

  assign rej_reason = rej_reason_q;

  // Running sum of amounts held in the FIFO; push and pop in one cycle both apply.
  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      inflight_amt <= '0;
    end else begin
      inflight_amt <= inflight_amt
                    + (push ? IW'(ord_amount)  : IW'(0))
                    - (pop  ? IW'(head.amount) : IW'(0));
    end
  end

  assign exch_client_id = exch_valid ? head.client_id : '0;
  assign exch_amount    = exch_valid ? head.amount    : '0;

  risk_order_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .HRESETn  (HRESETn),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

endmodule

// File: tb/tb_pretrade_risk_gate.sv
// Bench for pretrade_risk_gate: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pretrade_risk_gate;
  import risk_def::*;

  localparam int CW         = DEF_CLIENT_W;
  localparam int AW         = DEF_AMT_W;
  localparam int DEPTH      = 4;
  localparam int HALT_AFTER = 3;

  logic          clk;
  logic          HRESETn;
  logic          ord_valid;
  logic          ord_ready;
  logic [CW-1:0] ord_client_id;
  logic [AW-1:0] ord_amount;
  logic [15:0]   accumulated_orders;
  logic [31:0]   cancelled_orders;
  logic [31:0]   max_to_trade;
  logic          clear_halt;
  logic          exch_valid;
  logic          exch_ready;
  logic [CW-1:0] exch_client_id;
  logic [AW-1:0] exch_amount;
  logic          rej_valid;
  logic [CW-1:0] rej_client_id;
  logic [1:0]    rej_reason;
  logic          halted;
  logic [AW+1:0] inflight_amt;

  pretrade_risk_gate #(
    .CLIENT_W(CW), .AMT_W(AW), .DEPTH(DEPTH), .HALT_AFTER(HALT_AFTER)
  ) dut (
    .clk               (clk),
    .HRESETn           (HRESETn),
    .ord_valid         (ord_valid),
    .ord_ready         (ord_ready),
    .ord_client_id     (ord_client_id),
    .ord_amount        (ord_amount),
    .accumulated_orders(accumulated_orders),
    .cancelled_orders  (cancelled_orders),
    .max_to_trade      (max_to_trade),
    .clear_halt        (clear_halt),
    .exch_valid        (exch_valid),
    .exch_ready        (exch_ready),
    .exch_client_id    (exch_client_id),
    .exch_amount       (exch_amount),
    .rej_valid         (rej_valid),
    .rej_client_id     (rej_client_id),
    .rej_reason        (rej_reason),
    .halted            (halted),
    .inflight_amt      (inflight_amt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int amt;
  } m_ord_t;

  m_ord_t mq[$];
  bit     m_live     = 1'b0;
  bit     m_halted   = 1'b0;
  int     m_cnt      = 0;
  bit     m_rej_v    = 1'b0;
  int     m_rej_id   = 0;
  int     m_rej_rsn  = 0;

  function automatic int m_sum();
    int s = 0;
    foreach (mq[i]) s += mq[i].amt;
    return s;
  endfunction

  // Model update on each rising edge from the inputs held stable across it.
  always @(posedge clk) begin
    if (!HRESETn) begin
      mq.delete();
      m_live    = 1'b1;
      m_halted  = 1'b0;
      m_cnt     = 0;
      m_rej_v   = 1'b0;
      m_rej_id  = 0;
      m_rej_rsn = 0;
    end else if (m_live) begin
      bit     acc_ok, do_pop, pass;
      int     expo, rsn;
      m_ord_t o;
      acc_ok = ord_valid && (mq.size() < DEPTH);
      do_pop = (mq.size() > 0) && exch_ready;
      expo   = int'(accumulated_orders) - int'(cancelled_orders[15:0]) + m_sum() + int'(ord_amount);
      pass   = int'(max_to_trade[15:0]) > expo;
      if (m_halted)             rsn = 2;
      else if (ord_amount == 0) rsn = 3;
      else if (!pass)           rsn = 1;
      else                      rsn = 0;

      if (m_halted) begin
        if (clear_halt) begin
          m_halted = 1'b0;
          m_cnt    = 0;
        end
      end else if (acc_ok) begin
        if (rsn == 1) m_cnt++;
        if (rsn == 0) m_cnt = 0;
        if (m_cnt >= HALT_AFTER) m_halted = 1'b1;
      end

      if (do_pop) void'(mq.pop_front());
      if (acc_ok && rsn == 0) begin
        o.id  = int'(ord_client_id);
        o.amt = int'(ord_amount);
        mq.push_back(o);
      end

      m_rej_v   = acc_ok && (rsn != 0);
      m_rej_id  = m_rej_v ? int'(ord_client_id) : 0;
      m_rej_rsn = m_rej_v ? rsn : 0;
    end
  end

  // Compare every cycle, mid-period, once the model has seen a reset edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("m_ord_ready",  ord_ready,      mq.size() < DEPTH);
      check("m_exch_valid", exch_valid,     mq.size() > 0);
      check("m_exch_id",    exch_client_id, mq.size() > 0 ? mq[0].id  : 0);
      check("m_exch_amt",   exch_amount,    mq.size() > 0 ? mq[0].amt : 0);
      check("m_rej_valid",  rej_valid,      m_rej_v);
      check("m_rej_id",     rej_client_id,  m_rej_id);
      check("m_rej_reason", rej_reason,     m_rej_rsn);
      check("m_halted",     halted,         m_halted);
      check("m_inflight",   inflight_amt,   m_sum());
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input int amt);
    ord_valid     = 1'b1;
    ord_client_id = CW'(id);
    ord_amount    = AW'(amt);
    tick();
    ord_valid     = 1'b0;
  endtask

  initial begin
    HRESETn            = 1'b0;
    ord_valid          = 1'b1;
    ord_client_id      = '0;
    ord_amount         = 16'd1;
    accumulated_orders = '0;
    cancelled_orders   = '0;
    max_to_trade       = '0;
    clear_halt         = 1'b0;
    exch_ready         = 1'b0;

    // T1 reset with an order offered
    tick(); tick();
    check("t1_exch_valid", exch_valid,   0);
    check("t1_rej_valid",  rej_valid,    0);
    check("t1_ord_ready",  ord_ready,    1);
    check("t1_inflight",   inflight_amt, 0);
    check("t1_halted",     halted,       0);
    ord_valid = 1'b0;
    HRESETn   = 1'b1;
    tick();

    // T2 pass; upper halves of cancelled/max carry junk that must be ignored
    max_to_trade       = 32'h0001_0064;
    accumulated_orders = 16'd40;
    cancelled_orders   = 32'h0001_000A;
    exch_ready         = 1'b1;
    send(5, 20);
    check("t2_exch_valid", exch_valid,     1);
    check("t2_exch_id",    exch_client_id, 5);
    check("t2_exch_amt",   exch_amount,    20);
    check("t2_no_rej",     rej_valid,      0);
    tick();
    check("t2_drained",    exch_valid,     0);

    // T3 limit boundary: 90+10 = 100 is not below 100
    max_to_trade       = 32'd100;
    accumulated_orders = 16'd90;
    cancelled_orders   = 32'd0;
    send(9, 10);
    check("t3_rej_valid",  rej_valid,      1);
    check("t3_rej_reason", rej_reason,     1);
    check("t3_rej_id",     rej_client_id,  9);
    send(9, 9);
    check("t3_pass",       exch_valid,     1);
    check("t3_pass_amt",   exch_amount,    9);
    tick();

    // T4 backpressure: four fill the queue, the fifth waits for a pop
    accumulated_orders = 16'd0;
    exch_ready         = 1'b0;
    ord_valid          = 1'b1;
    ord_amount         = 16'd1;
    for (int i = 1; i <= 4; i++) begin
      ord_client_id = CW'(i);
      tick();
    end
    check("t4_full_ready", ord_ready,    0);
    check("t4_inflight4",  inflight_amt, 4);
    ord_client_id = CW'(5);
    tick(); tick();
    check("t4_held_head",  exch_client_id, 1);
    exch_ready = 1'b1;
    tick();
    check("t4_head2",      exch_client_id, 2);
    check("t4_inflight3",  inflight_amt,   3);
    tick();
    ord_valid = 1'b0;
    check("t4_head3",      exch_client_id, 3);
    tick(); tick();
    check("t4_head5",      exch_client_id, 5);
    tick();
    check("t4_empty",      exch_valid,     0);
    check("t4_inflight0",  inflight_amt,   0);

    // T5 kill switch
    accumulated_orders = 16'd200;
    send(1, 1); send(1, 1);
    check("t5_not_yet",    halted,       0);
    send(1, 1);
    check("t5_halted",     halted,       1);
    accumulated_orders = 16'd0;
    send(7, 10);
    check("t5_rej_halt",   rej_reason,   2);
    check("t5_rej_valid",  rej_valid,    1);
    clear_halt = 1'b1;
    tick();
    clear_halt = 1'b0;
    check("t5_cleared",    halted,       0);
    send(7, 10);
    check("t5_pass_id",    exch_client_id, 7);
    check("t5_pass_norej", rej_valid,      0);
    tick();

    // T6 zero amount does not disturb the reject streak
    accumulated_orders = 16'd200;
    send(2, 1); send(2, 1);
    send(3, 0);
    check("t6_rej_zero",   rej_reason,   3);
    check("t6_zero_run",   halted,       0);
    send(2, 1);
    check("t6_halt_after_zero", halted,  1);
    clear_halt = 1'b1;
    tick();
    clear_halt = 1'b0;

    // T6 reset with orders queued drops them
    accumulated_orders = 16'd0;
    exch_ready         = 1'b0;
    send(4, 5); send(4, 6);
    check("t6_inflight11", inflight_amt, 11);
    HRESETn = 1'b0;
    tick();
    check("t6_rst_exch",   exch_valid,   0);
    check("t6_rst_infl",   inflight_amt, 0);
    check("t6_rst_ready",  ord_ready,    1);
    HRESETn = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
